// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: EX-stage ALU control decode plus iterative shift-add multiplier.
// Define ALUCTL_MULH_EN to add signed high-half MULH (2*XLEN accumulator).
module alu_ctrl_mc #(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [9:0]      funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [2:0]      ALUCtrl_o,
  output logic            illegal_o,
  output logic            stall_o,
  output logic            mul_done_o,
  output logic [XLEN-1:0] mul_result_o
);

  localparam int N  = XLEN / BITS_PER_CYC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
`ifdef ALUCTL_MULH_EN
  localparam int AW = 2 * XLEN;
`else
  localparam int AW = XLEN;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [6:0]      f7;
  logic [2:0]      f3;
  logic            op_r, op_i, op_s, op_b;
  logic [2:0]      ctrl;
  logic            legal;
  logic            is_mul;
  logic            start;
  logic            last;

  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_nxt;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] res_nxt;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] a_in, b_in;

`ifdef ALUCTL_MULH_EN
  logic            is_mulh;
  logic            neg_q;
  logic            op_h;
  logic [AW-1:0]   prod;
`endif

  assign f7   = funct_i[9:3];
  assign f3   = funct_i[2:0];
  assign op_r = (ALUOp_i == 2'b00);
  assign op_i = (ALUOp_i == 2'b01);
  assign op_s = (ALUOp_i == 2'b10);
  assign op_b = (ALUOp_i == 2'b11);

  always_comb begin
    ctrl   = 3'b000;
    legal  = 1'b0;
    is_mul = 1'b0;
`ifdef ALUCTL_MULH_EN
    is_mulh = 1'b0;
`endif
    unique case (1'b1)
      op_r && funct_i == 10'b0000000000: legal = 1'b1;
      op_r && funct_i == 10'b0100000000: begin
        ctrl  = 3'b001;
        legal = 1'b1;
      end
      op_r && funct_i == 10'b0000000111: begin
        ctrl  = 3'b010;
        legal = 1'b1;
      end
      op_r && funct_i == 10'b0000000100: begin
        ctrl  = 3'b011;
        legal = 1'b1;
      end
      op_r && funct_i == 10'b0000001000: begin
        ctrl   = 3'b100;
        legal  = 1'b1;
        is_mul = 1'b1;
      end
      op_r && funct_i == 10'b0000000001: begin
        ctrl  = 3'b101;
        legal = 1'b1;
      end
`ifdef ALUCTL_MULH_EN
      op_r && funct_i == 10'b0000001001: begin
        ctrl    = 3'b111;
        legal   = 1'b1;
        is_mul  = 1'b1;
        is_mulh = 1'b1;
      end
`endif
      op_i && f3 == 3'b000: legal = 1'b1;
      op_i && f3 == 3'b010: legal = 1'b1;
      op_i && f3 == 3'b101 && f7 == 7'b0100000: begin
        ctrl  = 3'b110;
        legal = 1'b1;
      end
      op_s && f3 == 3'b010: legal = 1'b1;
      op_b && f3 == 3'b000: begin
        ctrl  = 3'b001;
        legal = 1'b1;
      end
      default: ;
    endcase
  end

  // Decode outputs are forced quiet while reset is held.
  assign ALUCtrl_o = rst_i ? ctrl : 3'b000;
  assign illegal_o = rst_i & valid_i & ~legal;

  assign start = rst_i && valid_i && !flush_i && is_mul
                 && state == S_IDLE;
  assign last  = (cnt == CW'(N - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_BUSY;
      S_BUSY: begin
        if (flush_i)   state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall_o      = start || (state == S_BUSY && !flush_i);
  assign mul_done_o   = (state == S_DONE);
  assign mul_result_o = result_q;

  always_comb begin
    pp = '0;
    for (int b = 0; b < BITS_PER_CYC; b++) begin
      if (mplier[b]) pp = pp + (mcand << b);
    end
  end

  assign acc_nxt = acc + pp;

`ifdef ALUCTL_MULH_EN
  // MULH runs on magnitudes; sign is restored on the final product.
  assign a_in = (is_mulh && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign b_in = (is_mulh && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
  assign prod = neg_q ? -acc_nxt : acc_nxt;
  assign res_nxt = op_h ? prod[AW-1:XLEN] : prod[XLEN-1:0];
`else
  assign a_in    = rs1_i;
  assign b_in    = rs2_i;
  assign res_nxt = acc_nxt;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
`ifdef ALUCTL_MULH_EN
      neg_q    <= 1'b0;
      op_h     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= AW'(a_in);
            mplier <= b_in;
`ifdef ALUCTL_MULH_EN
            op_h   <= is_mulh;
            neg_q  <= is_mulh & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
`endif
          end
        end
        S_BUSY: begin
          if (!flush_i) begin
            acc    <= acc_nxt;
            mcand  <= mcand << BITS_PER_CYC;
            mplier <= mplier >> BITS_PER_CYC;
            cnt    <= cnt + CW'(1);
            if (last) result_q <= res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb_alu_ctrl_mc: decode table vectors, decode sweep, multiplier sequences.
// Instance 0 retires 1 bit/cycle, instance 1 retires 4 bits/cycle.
module tb_alu_ctrl_mc;

  logic        clk;
  logic        rst_n;
  logic        valid  [2];
  logic        flush  [2];
  logic [9:0]  funct  [2];
  logic [1:0]  aluop  [2];
  logic [31:0] rs1    [2];
  logic [31:0] rs2    [2];
  logic [2:0]  ctrl   [2];
  logic        ill    [2];
  logic        stall  [2];
  logic        done   [2];
  logic [31:0] res    [2];
  logic [31:0] last_exp [2];

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] F_MUL  = 10'b0000001000;
  localparam logic [9:0] F_MULH = 10'b0000001001;

  alu_ctrl_mc #(.XLEN(32), .BITS_PER_CYC(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid[0]), .flush_i(flush[0]),
    .funct_i(funct[0]), .ALUOp_i(aluop[0]), .rs1_i(rs1[0]), .rs2_i(rs2[0]),
    .ALUCtrl_o(ctrl[0]), .illegal_o(ill[0]), .stall_o(stall[0]),
    .mul_done_o(done[0]), .mul_result_o(res[0])
  );

  alu_ctrl_mc #(.XLEN(32), .BITS_PER_CYC(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid[1]), .flush_i(flush[1]),
    .funct_i(funct[1]), .ALUOp_i(aluop[1]), .rs1_i(rs1[1]), .rs2_i(rs2[1]),
    .ALUCtrl_o(ctrl[1]), .illegal_o(ill[1]), .stall_o(stall[1]),
    .mul_done_o(done[1]), .mul_result_o(res[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [9:0] f;
    logic       v;
    logic [2:0] ctrl;
    logic       ill;
  } dvec_t;

  dvec_t tbl [18];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Starts at posedge+1; returns at the negedge of the DONE cycle.
  task automatic mul_seq(input int d, input logic [9:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_stall,
                         input string nm);
    int n;
    bit got;
    n   = 0;
    got = 0;
    valid[d] = 1'b1;
    flush[d] = 1'b0;
    funct[d] = f;
    aluop[d] = 2'b00;
    rs1[d]   = a;
    rs2[d]   = b;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done[d]) begin
        got = 1;
        break;
      end
      if (stall[d]) n++;
      @(posedge clk);
      #1;
      valid[d] = 1'b0;
      rs1[d]   = ~a;
      rs2[d]   = ~b;
    end
    check({nm, "_done_seen"}, 64'(got), 64'd1);
    check({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    check({nm, "_result"}, 64'(res[d]), 64'(exp));
    check({nm, "_stall_in_done"}, 64'(stall[d]), 64'd0);
    last_exp[d] = exp;
  endtask

  task automatic watch_quiet(input int d, input int cycles,
                             input string nm);
    int nd;
    int ns;
    nd = 0;
    ns = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done[d]) nd++;
      if (stall[d]) ns++;
    end
    check({nm, "_no_done"}, 64'(nd), 64'd0);
    check({nm, "_no_stall"}, 64'(ns), 64'd0);
  endtask

  initial begin
    int legal_cnt;
    int n111;
    int exp_legal;
    int exp_111;

    tbl[0]  = '{2'b00, 10'b0000000000, 1'b1, 3'b000, 1'b0};
    tbl[1]  = '{2'b00, 10'b0100000000, 1'b1, 3'b001, 1'b0};
    tbl[2]  = '{2'b00, 10'b0000000111, 1'b1, 3'b010, 1'b0};
    tbl[3]  = '{2'b00, 10'b0000000100, 1'b1, 3'b011, 1'b0};
    tbl[4]  = '{2'b00, 10'b0000001000, 1'b1, 3'b100, 1'b0};
    tbl[5]  = '{2'b00, 10'b0000000001, 1'b1, 3'b101, 1'b0};
    tbl[6]  = '{2'b00, 10'b1111111000, 1'b1, 3'b000, 1'b1};
    tbl[7]  = '{2'b00, 10'b0100000101, 1'b1, 3'b000, 1'b1};
    tbl[8]  = '{2'b01, 10'b1010101000, 1'b1, 3'b000, 1'b0};
    tbl[9]  = '{2'b01, 10'b0000000010, 1'b1, 3'b000, 1'b0};
    tbl[10] = '{2'b01, 10'b0100000101, 1'b1, 3'b110, 1'b0};
    tbl[11] = '{2'b01, 10'b0000000101, 1'b1, 3'b000, 1'b1};
    tbl[12] = '{2'b10, 10'b0000000010, 1'b1, 3'b000, 1'b0};
    tbl[13] = '{2'b10, 10'b0000000000, 1'b1, 3'b000, 1'b1};
    tbl[14] = '{2'b11, 10'b0000000000, 1'b1, 3'b001, 1'b0};
    tbl[15] = '{2'b11, 10'b0000000001, 1'b1, 3'b000, 1'b1};
    tbl[16] = '{2'b00, 10'b1111111000, 1'b0, 3'b000, 1'b0};
`ifdef ALUCTL_MULH_EN
    tbl[17] = '{2'b00, 10'b0000001001, 1'b1, 3'b111, 1'b0};
    exp_legal = 520;
    exp_111   = 1;
`else
    tbl[17] = '{2'b00, 10'b0000001001, 1'b1, 3'b000, 1'b1};
    exp_legal = 519;
    exp_111   = 0;
`endif

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b1;
      flush[d] = 1'b0;
      funct[d] = F_MUL;
      aluop[d] = 2'b00;
      rs1[d]   = 32'd7;
      rs2[d]   = 32'd6;
      last_exp[d] = 32'd0;
    end
    #12;
    check("rst_ctrl", 64'(ctrl[0]), 64'd0);
    check("rst_illegal", 64'(ill[0]), 64'd0);
    check("rst_stall", 64'(stall[0]), 64'd0);
    check("rst_done", 64'(done[0]), 64'd0);
    check("rst_result", 64'(res[0]), 64'd0);
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Decode vectors; flush keeps MUL encodings from starting.
    flush[0] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      aluop[0] = tbl[i].op;
      funct[0] = tbl[i].f;
      valid[0] = tbl[i].v;
      #1;
      check($sformatf("dec%0d_ctrl", i), 64'(ctrl[0]), 64'(tbl[i].ctrl));
      check($sformatf("dec%0d_ill", i), 64'(ill[0]), 64'(tbl[i].ill));
    end

    legal_cnt = 0;
    n111      = 0;
    valid[0]  = 1'b1;
    for (int o = 0; o < 4; o++) begin
      for (int f = 0; f < 1024; f++) begin
        aluop[0] = 2'(o);
        funct[0] = 10'(f);
        #1;
        if (!ill[0]) legal_cnt++;
        if (ctrl[0] == 3'b111) n111++;
      end
    end
    check("sweep_legal_count", 64'(legal_cnt), 64'(exp_legal));
    check("sweep_ctrl111_count", 64'(n111), 64'(exp_111));
    check("sweep_no_start", 64'(stall[0]), 64'd0);

    valid[0] = 1'b0;
    flush[0] = 1'b0;
    @(posedge clk);
    #1;

    mul_seq(0, F_MUL, 32'd7, 32'd6, 32'd42, 33, "mul7x6");
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    @(negedge clk);
    check("mul7x6_after_stall", 64'(stall[0]), 64'd0);
    check("mul7x6_after_done", 64'(done[0]), 64'd0);
    check("mul7x6_hold", 64'(res[0]), 64'd42);
    @(posedge clk);
    #1;

    mul_seq(0, F_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, "mulwrap");
    @(posedge clk);
    #1;
    valid[0] = 1'b0;

`ifdef ALUCTL_MULH_EN
    mul_seq(0, F_MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 33, "mulh_m3x5");
    @(posedge clk);
    #1;
    mul_seq(0, F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33,
            "mulh_min");
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
`endif

    // Back-to-back on the 4-bit/cycle instance.
    mul_seq(1, F_MUL, 32'd3, 32'd3, 32'd9, 9, "bpc4_3x3");
    @(posedge clk);
    #1;
    mul_seq(1, F_MUL, 32'd4, 32'd4, 32'd16, 9, "bpc4_4x4");
    @(posedge clk);
    #1;
    valid[1] = 1'b0;

    // Flush together with start: flush wins.
    valid[0] = 1'b1;
    funct[0] = F_MUL;
    aluop[0] = 2'b00;
    rs1[0]   = 32'd9;
    rs2[0]   = 32'd9;
    flush[0] = 1'b1;
    @(negedge clk);
    check("flushstart_stall", 64'(stall[0]), 64'd0);
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    valid[0] = 1'b0;
    watch_quiet(0, 3, "flushstart");

    // Flush mid-BUSY at count 10.
    @(posedge clk);
    #1;
    valid[0] = 1'b1;
    rs1[0]   = 32'd11;
    rs2[0]   = 32'd13;
    repeat (11) begin
      @(posedge clk);
      #1;
      valid[0] = 1'b0;
    end
    check("flushbusy_stall_before", 64'(stall[0]), 64'd1);
    flush[0] = 1'b1;
    #1;
    check("flushbusy_stall_drop", 64'(stall[0]), 64'd0);
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    watch_quiet(0, 40, "flushbusy");
    check("flushbusy_result_hold", 64'(res[0]), 64'(last_exp[0]));

    // Reset mid-BUSY at count 5.
    @(posedge clk);
    #1;
    valid[0] = 1'b1;
    funct[0] = F_MUL;
    rs1[0]   = 32'd5;
    rs2[0]   = 32'd5;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("rstbusy_stall_before", 64'(stall[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstbusy_stall", 64'(stall[0]), 64'd0);
    check("rstbusy_done", 64'(done[0]), 64'd0);
    check("rstbusy_result", 64'(res[0]), 64'd0);
    check("rstbusy_ctrl", 64'(ctrl[0]), 64'd0);
    check("rstbusy_illegal", 64'(ill[0]), 64'd0);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    rst_n    = 1'b1;
    watch_quiet(0, 40, "rstbusy");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
